// File: rtl/arr_bank_ctrl_if.sv
// Host/kernel access bus for arr_bank_ctrl. The master side drives requests;
// the slave side (the bank) returns grants, read data and status.
interface arr_bank_ctrl_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 4
);
  logic              controlArr;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic [DATA_W-1:0] host_rdata;
  logic              host_rvalid;
  logic              kern_req;
  logic              kern_we;
  logic [ADDR_W-1:0] kern_addr;
  logic [DATA_W-1:0] kern_wdata;
  logic              kern_gnt;
  logic [DATA_W-1:0] kern_rdata;
  logic              kern_rvalid;
  logic              busy;
  logic              addr_err;

  modport master (
    output controlArr, host_we, host_addr, host_wdata,
    output kern_req, kern_we, kern_addr, kern_wdata,
    input  host_rdata, host_rvalid, kern_gnt, kern_rdata, kern_rvalid,
    input  busy, addr_err
  );

  modport slave (
    input  controlArr, host_we, host_addr, host_wdata,
    input  kern_req, kern_we, kern_addr, kern_wdata,
    output host_rdata, host_rvalid, kern_gnt, kern_rdata, kern_rvalid,
    output busy, addr_err
  );
endinterface

// File: rtl/arr_bank_ctrl.sv
// Single-port array bank shared between a host (owner while controlArr=1) and a kernel.
// Define ARR_BANK_CLEAR_EN to build the post-reset zero-clear engine.
module arr_bank_ctrl #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  arr_bank_ctrl_if.slave bus
);

  typedef struct packed {
    logic              vld;
    logic              we;
    logic              host;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } acc_t;

  logic              ready;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  acc_t              acc;
  logic              in_range;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] mem [DEPTH];

`ifdef ARR_BANK_CLEAR_EN
  typedef enum logic {CLEAR, READY} state_t;
  state_t state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= CLEAR;
      clr_addr <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == CLEAR) clr_addr <= (state_d == READY) ? '0 : clr_addr + ADDR_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR: if (clr_addr == ADDR_W'(DEPTH - 1)) state_d = READY;
      READY: state_d = READY;
    endcase
  end

  assign ready    = rst_n & (state_q == READY);
  assign clr_we   = (state_q == CLEAR);
  assign bus.busy = (state_q == CLEAR);
`else
  assign ready    = rst_n;
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
  assign bus.busy = 1'b0;
`endif

  // Reset gates the grant combinationally so it drops the instant rst_n falls.
  assign bus.kern_gnt = bus.kern_req & ~bus.controlArr & ready;

  always_comb begin
    acc = '0;
    if (ready && bus.controlArr) begin
      acc.vld   = 1'b1;
      acc.we    = bus.host_we;
      acc.host  = 1'b1;
      acc.addr  = bus.host_addr;
      acc.wdata = bus.host_wdata;
    end else if (bus.kern_gnt) begin
      acc.vld   = 1'b1;
      acc.we    = bus.kern_we;
      acc.addr  = bus.kern_addr;
      acc.wdata = bus.kern_wdata;
    end
  end

  // One extra bit so a power-of-two DEPTH does not wrap to zero.
  assign in_range  = {1'b0, acc.addr} < (ADDR_W + 1)'(DEPTH);
  assign mem_we    = clr_we | (acc.vld & acc.we & in_range);
  assign mem_waddr = clr_we ? clr_addr : acc.addr;
  assign mem_wdata = clr_we ? '0 : acc.wdata;
  assign rd_word   = in_range ? mem[acc.addr] : '0;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.host_rvalid <= 1'b0;
      bus.kern_rvalid <= 1'b0;
      bus.host_rdata  <= '0;
      bus.kern_rdata  <= '0;
      bus.addr_err    <= 1'b0;
    end else begin
      bus.host_rvalid <= acc.vld & ~acc.we &  acc.host;
      bus.kern_rvalid <= acc.vld & ~acc.we & ~acc.host;
      if (acc.vld && !acc.we &&  acc.host) bus.host_rdata <= rd_word;
      if (acc.vld && !acc.we && !acc.host) bus.kern_rdata <= rd_word;
      if (acc.vld && !in_range)            bus.addr_err   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_arr_bank_ctrl.sv
// Directed bench for arr_bank_ctrl (DEPTH=10 so addresses 10..15 are out of range).
// Read returns are checked by a negedge monitor against per-port expectation queues.
module tb_arr_bank_ctrl;
  localparam int DW    = 64;
  localparam int DEPTH = 10;
  localparam int AW    = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  arr_bank_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  arr_bank_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int              n_cmp = 0;
  int              n_err = 0;
  logic [DW-1:0]   hq[$];
  logic [DW-1:0]   kq[$];
  logic [DW-1:0]   last_h = '0;
  logic [DW-1:0]   last_k = '0;
  bit              mon_en = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.controlArr = 1'b0;
    bus.kern_req   = 1'b0;
    bus.host_we    = 1'b0;
    bus.kern_we    = 1'b0;
  endtask

  task automatic host(input bit we, input int a, input logic [DW-1:0] d, input logic [DW-1:0] exp);
    bus.controlArr = 1'b1;
    bus.kern_req   = 1'b0;
    bus.host_we    = we;
    bus.host_addr  = AW'(a);
    bus.host_wdata = d;
    if (!we) hq.push_back(exp);
    step();
  endtask

  task automatic kern(input bit we, input int a, input logic [DW-1:0] d, input logic [DW-1:0] exp);
    bus.controlArr = 1'b0;
    bus.kern_req   = 1'b1;
    bus.kern_we    = we;
    bus.kern_addr  = AW'(a);
    bus.kern_wdata = d;
    if (!we) kq.push_back(exp);
    #1 chk("kern_gnt_granted", DW'(bus.kern_gnt), 1);
    step();
  endtask

  // Read-return monitor: pops on rvalid, otherwise checks rdata is held.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.host_rvalid) begin
        if (hq.size() == 0) chk("host_rvalid_unexpected", DW'(bus.host_rvalid), 0);
        else begin
          last_h = hq.pop_front();
          chk("host_rdata", bus.host_rdata, last_h);
        end
      end else chk("host_rdata_hold", bus.host_rdata, last_h);
      if (bus.kern_rvalid) begin
        if (kq.size() == 0) chk("kern_rvalid_unexpected", DW'(bus.kern_rvalid), 0);
        else begin
          last_k = kq.pop_front();
          chk("kern_rdata", bus.kern_rdata, last_k);
        end
      end else chk("kern_rdata_hold", bus.kern_rdata, last_k);
      if (bus.host_rvalid || bus.kern_rvalid)
        chk("rvalid_exclusive", DW'(bus.host_rvalid & bus.kern_rvalid), 0);
    end
  end

`ifdef ARR_BANK_CLEAR_EN
  task automatic count_clear(input string name);
    int cnt;
    cnt = 0;
    while (bus.busy && cnt < 100) begin
      step();
      cnt++;
    end
    chk(name, DW'(cnt), DW'(DEPTH));
  endtask
`endif

  initial begin
    idle();
    bus.host_addr  = '0;
    bus.host_wdata = '0;
    bus.kern_addr  = '0;
    bus.kern_wdata = '0;
    rst_n = 1'b0;
    bus.kern_req = 1'b1;
    repeat (2) step();
    mon_en = 1'b1;
    chk("reset_kern_gnt", DW'(bus.kern_gnt), 0);
    chk("reset_addr_err", DW'(bus.addr_err), 0);
    idle();
    rst_n = 1'b1;

`ifdef ARR_BANK_CLEAR_EN
    bus.kern_req   = 1'b1;
    bus.kern_we    = 1'b1;
    bus.kern_wdata = 64'hF;
    #1 chk("clear_kern_gnt", DW'(bus.kern_gnt), 0);
    count_clear("clear_busy_cycles");
    idle();
    for (int i = 0; i < DEPTH; i++) host(1'b0, i, '0, '0);
`else
    step();
    chk("busy_tied_low", DW'(bus.busy), 0);
`endif

    // Host path
    host(1'b1, 3, 64'h1234, '0);
    host(1'b0, 3, '0, 64'h1234);
    host(1'b1, 7, 64'hDEAD_BEEF_0000_0001, '0);
    host(1'b0, 7, '0, 64'hDEAD_BEEF_0000_0001);
    host(1'b1, 3, 64'h55, '0);
    host(1'b0, 3, '0, 64'h55);
    host(1'b1, 1, 64'h22, '0);
    host(1'b1, 2, 64'hAA, '0);

    // Kernel request while host owns the array: no grant, write dropped
    bus.controlArr = 1'b1;
    bus.host_we    = 1'b0;
    bus.host_addr  = AW'(7);
    hq.push_back(64'hDEAD_BEEF_0000_0001);
    bus.kern_req   = 1'b1;
    bus.kern_we    = 1'b1;
    bus.kern_addr  = AW'(1);
    bus.kern_wdata = 64'h9;
    #1 chk("kern_gnt_blocked", DW'(bus.kern_gnt), 0);
    step();

    kern(1'b1, 0, 64'h5, '0);
    kern(1'b0, 0, '0, 64'h5);
    host(1'b0, 1, '0, 64'h22);     // ownership flips right after the kernel read
    kern(1'b0, 1, '0, 64'h22);     // blocked write left addr 1 untouched
    idle();
    step();
    chk("addr_err_clean", DW'(bus.addr_err), 0);

    // Out-of-range accesses
    kern(1'b1, 12, 64'h7, '0);
    chk("addr_err_set", DW'(bus.addr_err), 1);
    kern(1'b0, 12, '0, '0);
    kern(1'b0, 2, '0, 64'hAA);
    host(1'b0, 15, '0, '0);
    idle();
    repeat (3) step();
    chk("addr_err_sticky", DW'(bus.addr_err), 1);

    // Reset lands while a kernel read is being issued: that read never returns
    bus.controlArr = 1'b0;
    bus.kern_req   = 1'b1;
    bus.kern_we    = 1'b0;
    bus.kern_addr  = AW'(0);
    #1;
    rst_n  = 1'b0;
    last_h = '0;
    last_k = '0;
    #1;
    chk("reset_gnt_drop", DW'(bus.kern_gnt), 0);
    chk("reset_addr_err_clr", DW'(bus.addr_err), 0);
    repeat (2) step();
    idle();
    rst_n = 1'b1;

`ifdef ARR_BANK_CLEAR_EN
    repeat (5) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    count_clear("clear_restart_cycles");
    host(1'b0, 0, '0, '0);
    host(1'b0, DEPTH - 1, '0, '0);
    idle();
`endif

    repeat (3) step();
    chk("host_queue_drained", DW'(hq.size()), 0);
    chk("kern_queue_drained", DW'(kq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/arr_bank_ctrl.md
ARR_BANK_CTRL -- requirements
Module: arr_bank_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 64, array element width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, number of elements (any value >= 2, not restricted to powers of two).
REQ-003 SHALL have parameter ADDR_W, default $clog2(DEPTH), address width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port controlArr  input  1  host owns the array when 1.
REQ-007 SHALL have ports host_we  input  1, host_addr  input  ADDR_W, host_wdata  input  DATA_W  host access; a read is host_we=0.
REQ-008 SHALL have ports host_rdata  output  DATA_W, host_rvalid  output  1  host read return.
REQ-009 SHALL have ports kern_req  input  1, kern_we  input  1, kern_addr  input  ADDR_W, kern_wdata  input  DATA_W  kernel access.
REQ-010 SHALL have ports kern_gnt  output  1, kern_rdata  output  DATA_W, kern_rvalid  output  1  kernel grant and read return.
REQ-011 SHALL have ports busy  output  1 (clear in progress) and addr_err  output  1 (sticky out-of-range flag).

Function
REQ-012 SHALL be a single-port memory: at most one access per cycle.
REQ-013 SHALL treat the host as issuing an access every cycle controlArr=1 and state is READY.
REQ-014 SHALL assert kern_gnt combinationally only when kern_req=1, controlArr=0 and state READY; ungranted kernel requests have no effect and the kernel SHALL hold them.
REQ-015 SHALL commit a granted/host write at the clock edge of the access cycle.
REQ-016 SHALL return read data exactly one cycle after the read cycle, with rvalid high for that one cycle on the port that issued the read, even if controlArr changes in between.
REQ-017 SHALL hold host_rdata and kern_rdata at their last returned values when rvalid is low.
REQ-018 SHALL return written data to a read in the cycle after a write to the same address (no stale read).
REQ-019 SHALL, for addr >= DEPTH, ignore the write, return zero for a read (rvalid still asserted) and set addr_err, which stays 1 until reset.
REQ-020 SHALL implement states CLEAR and READY; READY -> READY always; CLEAR -> READY after the write of address DEPTH-1.
REQ-021 SHALL drive busy=1 exactly while in CLEAR; host and kernel accesses are ignored and kern_gnt=0 in CLEAR.

Reset
REQ-022 SHALL, on rst_n=0, immediately set kern_gnt=0, host_rvalid=0, kern_rvalid=0, host_rdata=0, kern_rdata=0, addr_err=0, clear-address counter=0.
REQ-023 SHALL enter CLEAR (macro defined) or READY (macro undefined) on reset; reset mid-clear restarts clear from address 0.
REQ-024 SHALL discard any read in flight at reset (no rvalid after release).

Configuration
REQ-025 SHALL compile the zero-clear engine only when ARR_BANK_CLEAR_EN is defined: after reset, write 0 to addresses 0..DEPTH-1, one per cycle, busy high for DEPTH cycles.
REQ-026 SHALL, without ARR_BANK_CLEAR_EN, omit CLEAR entirely: busy tied 0, memory contents undefined after reset, READY from the first cycle.

Verification
REQ-027 Clear: macro defined, DEPTH=16, release reset -> busy high 16 cycles, then host reads of addr 0..15 all return 0.
REQ-028 Host path: controlArr=1, write 0x1234 to addr 3, read addr 3 next cycle -> host_rvalid one cycle later with host_rdata=0x1234, kern_rvalid=0.
REQ-029 Arbitration: controlArr=1 with kern_req=1 -> kern_gnt=0 and memory unchanged; drop controlArr -> kern_gnt=1 same cycle, kernel write 5 to addr 0 lands.
REQ-030 Ownership switch: kernel read addr 0 granted, controlArr rises next cycle -> kern_rvalid=1 with data 5, host_rvalid=0.
REQ-031 Range: DEPTH=10, kernel write 7 to addr 12 then read addr 12 -> rdata 0, addr_err=1 and held until rst_n=0.
REQ-032 Reset mid-clear: rst_n pulsed low at clear cycle 5 -> busy stays high 16 full cycles after release, all outputs 0 during reset.
